// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions.
//   ctrState_e : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   MODE_*     : prediction mode selectors for the BTB MODE parameter
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctrState_e;

  localparam int unsigned MODE_STATIC  = 0;
  localparam int unsigned MODE_DYNAMIC = 1;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating branch counter.
//   ctr     : current counter state
//   taken   : resolved direction
//   jump    : unconditional jump (forces strongly taken)
//   nextCtr : updated counter state
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctrState_e ctr,
  input  logic      taken,
  input  logic      jump,
  output ctrState_e nextCtr
);

  always_comb begin
    nextCtr = ctr;
    if (jump) begin
      nextCtr = ST;
    end else if (taken) begin
      if (ctr != ST) nextCtr = ctrState_e'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nextCtr = ctrState_e'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Fetch side : PCF looked up combinationally -> TakenF, P_PCF.
// Execute side: BranchE/JumpE resolution trains the table, flags a
//               mispredict (MispredictE, RedirectPCE) and counts
//               resolved branches (BranchCnt) and mispredicts (MissCnt).
// clk/rst: rising-edge clock, synchronous active-high reset.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned MODE    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  output logic            TakenF,
  output logic [XLEN-1:0] P_PCF,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredPCE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCnt,
  output logic [31:0]     MissCnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam bit          PREDICT = (MODE == MODE_DYNAMIC);

  logic             validQ  [ENTRIES];
  logic [TAG_W-1:0] tagQ    [ENTRIES];
  logic [XLEN-1:0]  targetQ [ENTRIES];
  ctrState_e        ctrQ    [ENTRIES];

  logic [IDX_W-1:0] fetchIdx;
  logic [TAG_W-1:0] fetchTag;
  logic             fetchHit;
  logic [IDX_W-1:0] exIdx;
  logic [TAG_W-1:0] exTag;
  logic             exHit;
  logic             updateEn;
  ctrState_e        exNextCtr;

  // Byte-offset bits never participate in index or tag.
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup; reads registered state so it sees pre-update contents.
  assign fetchIdx = PCF[IDX_W+1:2];
  assign fetchTag = PCF[XLEN-1:IDX_W+2];
  assign fetchHit = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
  assign TakenF   = PREDICT && fetchHit &&
                    (ctrQ[fetchIdx] == WT || ctrQ[fetchIdx] == ST);
  assign P_PCF    = TakenF ? targetQ[fetchIdx] : PCF + XLEN'(4);

  // Execute-stage resolution.
  assign updateEn = BranchE | JumpE;
  assign exIdx    = PCE[IDX_W+1:2];
  assign exTag    = PCE[XLEN-1:IDX_W+2];
  assign exHit    = validQ[exIdx] && (tagQ[exIdx] == exTag);

  assign MispredictE = updateEn
                     ? ((PredTakenE != PCSrcE) || (PCSrcE && (PredPCE != PCTargetE)))
                     : PredTakenE;
  assign RedirectPCE = (updateEn && PCSrcE) ? PCTargetE : PCPlus4E;

  bp_sat_counter uSatCounter (
    .ctr     (ctrQ[exIdx]),
    .taken   (PCSrcE),
    .jump    (JumpE),
    .nextCtr (exNextCtr)
  );

  // Valid bits and counters: cleared on reset, trained on resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= WNT;
      end
    end else if (updateEn) begin
      if (exHit) begin
        ctrQ[exIdx] <= exNextCtr;
      end else if (PCSrcE) begin
        validQ[exIdx] <= 1'b1;
        ctrQ[exIdx]   <= JumpE ? ST : WT;
      end
    end
  end

  // Tags and targets carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (!rst && updateEn && PCSrcE) begin
      targetQ[exIdx] <= PCTargetE;
      if (!exHit) tagQ[exIdx] <= exTag;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCnt <= 32'd0;
      MissCnt   <= 32'd0;
    end else begin
      if (updateEn && BranchCnt != 32'hFFFF_FFFF) BranchCnt <= BranchCnt + 32'd1;
      if (MispredictE && MissCnt != 32'hFFFF_FFFF) MissCnt <= MissCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench: two BTBs (MODE=1 and MODE=0) share stimulus; a
// behavioural table model predicts outputs, a monitor compares them.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, PCTargetE, PCPlus4E, PredPCE;
  logic        BranchE, JumpE, PCSrcE, PredTakenE;

  logic        takenF1, takenF0, mis1, mis0;
  logic [31:0] ppcf1, ppcf0, redir1, redir0, bcnt1, bcnt0, mcnt1, mcnt0;

  always #5 clk = ~clk;

  branch_target_buffer #(.XLEN(32), .ENTRIES(16), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .PCF(PCF), .TakenF(takenF1), .P_PCF(ppcf1),
    .BranchE(BranchE), .JumpE(JumpE), .PCSrcE(PCSrcE), .PCE(PCE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .PredTakenE(PredTakenE),
    .PredPCE(PredPCE), .MispredictE(mis1), .RedirectPCE(redir1),
    .BranchCnt(bcnt1), .MissCnt(mcnt1)
  );

  branch_target_buffer #(.XLEN(32), .ENTRIES(16), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .PCF(PCF), .TakenF(takenF0), .P_PCF(ppcf0),
    .BranchE(BranchE), .JumpE(JumpE), .PCSrcE(PCSrcE), .PCE(PCE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .PredTakenE(PredTakenE),
    .PredPCE(PredPCE), .MispredictE(mis0), .RedirectPCE(redir0),
    .BranchCnt(bcnt0), .MissCnt(mcnt0)
  );

  typedef struct {
    string       name;
    logic        takenF1;
    logic [31:0] ppcf1;
    logic [31:0] ppcf0;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference table: plain arrays, index = (pc/4) mod 16, tag = pc/64.
  bit          mValid  [16];
  logic [31:0] mTag    [16];
  logic [31:0] mTarget [16];
  int          mCtr    [16];
  logic [31:0] mB, mM;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 1;
    end
    mB = 0;
    mM = 0;
  endtask

  // One cycle: drive inputs, queue expectation, then apply model update.
  task automatic step(input string name, input bit r, input logic [31:0] pcf,
                      input bit br, input bit jp, input bit tk,
                      input logic [31:0] pce, input logic [31:0] tgt,
                      input bit pt, input logic [31:0] ppc);
    exp_t e;
    int   fi, ei;
    bit   fhit, ehit, upd, misp;
    @(negedge clk);
    #1;
    rst = r; PCF = pcf; BranchE = br; JumpE = jp; PCSrcE = tk;
    PCE = pce; PCTargetE = tgt; PCPlus4E = pce + 32'd4;
    PredTakenE = pt; PredPCE = ppc;

    fi   = int'(pcf / 4) % 16;
    fhit = mValid[fi] && (mTag[fi] == pcf / 64);
    upd  = br || jp;
    misp = upd ? ((pt != tk) || (tk && ppc != tgt)) : pt;
    e.name    = name;
    e.takenF1 = fhit && (mCtr[fi] >= 2);
    e.ppcf1   = e.takenF1 ? mTarget[fi] : pcf + 32'd4;
    e.ppcf0   = pcf + 32'd4;
    e.mis     = misp;
    e.redir   = (upd && tk) ? tgt : pce + 32'd4;
    e.bcnt    = mB;
    e.mcnt    = mM;
    q.push_back(e);

    @(posedge clk);
    if (r) begin
      modelReset();
    end else begin
      if (upd && mB != 32'hFFFF_FFFF) mB++;
      if (misp && mM != 32'hFFFF_FFFF) mM++;
      if (upd) begin
        ei   = int'(pce / 4) % 16;
        ehit = mValid[ei] && (mTag[ei] == pce / 64);
        if (ehit) begin
          if (jp)      mCtr[ei] = 3;
          else if (tk) mCtr[ei] = (mCtr[ei] == 3) ? 3 : mCtr[ei] + 1;
          else         mCtr[ei] = (mCtr[ei] == 0) ? 0 : mCtr[ei] - 1;
          if (tk) mTarget[ei] = tgt;
        end else if (tk) begin
          mValid[ei]  = 1'b1;
          mTag[ei]    = pce / 64;
          mTarget[ei] = tgt;
          mCtr[ei]    = jp ? 3 : 2;
        end
      end
    end
  endtask

  task automatic lookup(input string name, input logic [31:0] pcf);
    step(name, 1'b0, pcf, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic doReset();
    step("reset", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("reset", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: outputs are combinational, so every queued cycle is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "TakenF1",  32'(takenF1), 32'(e.takenF1));
        chk(e.name, "P_PCF1",   ppcf1,        e.ppcf1);
        chk(e.name, "TakenF0",  32'(takenF0), 32'd0);
        chk(e.name, "P_PCF0",   ppcf0,        e.ppcf0);
        chk(e.name, "Mispred1", 32'(mis1),    32'(e.mis));
        chk(e.name, "Mispred0", 32'(mis0),    32'(e.mis));
        chk(e.name, "Redir1",   redir1,       e.redir);
        chk(e.name, "Redir0",   redir0,       e.redir);
        chk(e.name, "BrCnt1",   bcnt1,        e.bcnt);
        chk(e.name, "BrCnt0",   bcnt0,        e.bcnt);
        chk(e.name, "MissCnt1", mcnt1,        e.mcnt);
        chk(e.name, "MissCnt0", mcnt0,        e.mcnt);
      end
    end
  end

  initial begin
    logic [31:0] pce, tgt, ppc;
    bit          br, jp, tk, pt, r;
    int          kind;

    rst = 1'b1; PCF = '0; BranchE = 0; JumpE = 0; PCSrcE = 0; PCE = '0;
    PCTargetE = '0; PCPlus4E = '0; PredTakenE = 0; PredPCE = '0;
    for (int i = 0; i < 16; i++) begin
      mTag[i]    = '0;
      mTarget[i] = '0;
    end
    modelReset();

    // Reset state and first allocation / training sequence.
    doReset();
    lookup("rstLookup", 32'h100);
    step("alloc40", 0, 32'h0, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44);
    lookup("hit40", 32'h40);
    step("nt1", 0, 32'h40, 1, 0, 0, 32'h40, 32'h20, 1, 32'h20);
    step("nt2", 0, 32'h40, 1, 0, 0, 32'h40, 32'h20, 0, 32'h44);
    lookup("cold40", 32'h40);

    // Aliasing eviction on index 0.
    doReset();
    step("alloc40b", 0, 32'h0, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44);
    step("alloc80", 0, 32'h0, 1, 0, 1, 32'h80, 32'h200, 0, 32'h84);
    lookup("evict40", 32'h40);
    lookup("hit80", 32'h80);

    // Read-before-write, jump allocation, reset-discarded update.
    doReset();
    step("rbw40", 0, 32'h40, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44);
    lookup("rbw40next", 32'h40);
    step("jmp104", 0, 32'h104, 1'b0, 1'b1, 1'b1, 32'h104, 32'h300, 0, 32'h108);
    step("jmpNt1", 0, 32'h104, 1, 0, 0, 32'h104, 32'h300, 1, 32'h300);
    lookup("jmpStillT", 32'h104);
    step("rstUpd", 1, 32'h0, 1, 0, 1, 32'h48, 32'h80, 0, 32'h4C);
    lookup("rstUpdMiss", 32'h48);

    // Randomized traffic over a small aliasing address pool.
    for (int n = 0; n < 500; n++) begin
      pce  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      tgt  = 32'($urandom_range(0, 255)) << 2;
      kind = $urandom_range(0, 9);
      br   = (kind <= 5);
      jp   = (kind == 6);
      tk   = jp ? 1'b1 : 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ppc = tgt;
        1:       ppc = pce + 32'd4;
        default: ppc = tgt ^ 32'h10;
      endcase
      r = ($urandom_range(0, 39) == 0);
      step("rand", r,
           (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2),
           br, jp, tk, pce, tgt, pt, ppc);
    end

    repeat (3) @(negedge clk);
    #4;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter XLEN, 32, address/data width.
REQ-002 SHALL have parameter ENTRIES, 16, table depth (power of 2, 4..256); IDX_W = log2(ENTRIES), TAG_W = XLEN-IDX_W-2.
REQ-003 SHALL have parameter MODE, 1, 0 = static not-taken (table trains, TakenF forced 0), 1 = 2-bit counter prediction.
REQ-004 SHALL use one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  PCF  in  XLEN  fetch PC (lookup)
  TakenF  out  1  predict taken for PCF
  P_PCF  out  XLEN  predicted next PC
  BranchE  in  1  conditional branch resolving in E
  JumpE  in  1  jump resolving in E
  PCSrcE  in  1  actual taken
  PCE  in  XLEN  PC of E instruction
  PCTargetE  in  XLEN  actual target
  PCPlus4E  in  XLEN  PCE+4
  PredTakenE  in  1  TakenF carried to E with instruction
  PredPCE  in  XLEN  P_PCF carried to E
  MispredictE  out  1  redirect required
  RedirectPCE  out  XLEN  corrected PC
  BranchCnt  out  32  resolved branch/jump count
  MissCnt  out  32  mispredict count

Function
REQ-005 Entry SHALL hold valid, tag[TAG_W], target[XLEN], ctr[2]; index = PC[IDX_W+1:2], tag = PC[XLEN-1:IDX_W+2].
REQ-006 Lookup SHALL be combinational, zero latency: hit = valid & tag match; TakenF = hit & ctr[1] & (MODE==1).
REQ-007 P_PCF SHALL be target when TakenF=1, else PCF+4 (mod 2^XLEN).
REQ-008 Update SHALL occur on the clock edge when BranchE|JumpE=1; drivers hold BranchE=JumpE=0 for bubbles/flushed slots.
REQ-009 Update hit: ctr saturating +1 if PCSrcE else -1 (floor 00, ceiling 11); JumpE sets ctr=11; target overwritten with PCTargetE when PCSrcE=1.
REQ-010 Update miss: if PCSrcE=1 allocate (evict occupant): valid=1, tag, target=PCTargetE, ctr=10 (branch) or 11 (jump); if PCSrcE=0 no change.
REQ-011 MispredictE SHALL be combinational: (BranchE|JumpE) & (PredTakenE!=PCSrcE | (PCSrcE & PredPCE!=PCTargetE)), or (!BranchE & !JumpE & PredTakenE).
REQ-012 RedirectPCE SHALL be PCTargetE when (BranchE|JumpE)&PCSrcE, else PCPlus4E.
REQ-013 Same-index lookup and update in one cycle: lookup SHALL return pre-update contents (read-before-write).
REQ-014 BranchCnt SHALL increment per update cycle; MissCnt per MispredictE=1 cycle; both saturate at 0xFFFFFFFF.
REQ-015 MODE=0: table and counters update identically; TakenF=0, P_PCF=PCF+4 always.

Reset
REQ-016 rst=1 at an edge SHALL clear all valid bits, ctr to 01, BranchCnt/MissCnt to 0; tags/targets need not reset.
REQ-017 After reset TakenF=0, P_PCF=PCF+4 for every PCF.
REQ-018 Update coincident with rst=1 SHALL be discarded.

Structure
REQ-019 Shared package bp_pkg SHALL hold counter encodings (SNT=00, WNT=01, WT=10, ST=11) and MODE constants.
REQ-020 Saturating 2-bit next-state logic SHALL be sub-module bp_sat_counter (inputs ctr, taken, jump; output next ctr).
REQ-021 Table SHALL be flops (no RAM macro) to support combinational read.

Verification (ENTRIES=16, MODE=1)
REQ-022 Reset, PCF=0x100 -> TakenF=0, P_PCF=0x104, counters 0.
REQ-023 BranchE=1 PCE=0x40 PCSrcE=1 PCTargetE=0x20 PredTakenE=0 -> MispredictE=1, RedirectPCE=0x20; next cycle PCF=0x40 -> TakenF=1, P_PCF=0x20.
REQ-024 Then PCE=0x40 not-taken twice, PredTakenE=1 first -> RedirectPCE=0x44, MispredictE=1; ctr 10->01->00; PCF=0x40 -> TakenF=0.
REQ-025 Allocate 0x40->0x20, then 0x80->0x200 taken (same index 0) -> PCF=0x40 misses (P_PCF=0x44), PCF=0x80 -> P_PCF=0x200.
REQ-026 Lookup PCF=0x40 in same cycle as its first allocating update -> TakenF=0 that cycle, 1 next cycle; JumpE allocate -> ctr=11.
REQ-027 MODE=0, repeat REQ-023 -> TakenF stays 0, BranchCnt=1, MissCnt=1; rst asserted with update -> entry not allocated.
